lcd_timing_driver: RTL and testbench

LCD_TIMING_DRIVER -- requirements
Module: lcd_timing_driver

---
 rtl/lcd_timing_driver.sv | 78 +++++++
 tb/tb_lcd_timing_driver.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/lcd_timing_driver.sv
// Raster timing generator for a parallel RGB panel: free-running h/v counters,
// active-low syncs, a one-clock-early coordinate request and gated pixel output.
module lcd_timing_driver #(
    parameter int H_SYNC  = 128,
    parameter int H_BACK  = 88,
    parameter int H_DISP  = 800,
    parameter int H_FRONT = 40,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_DISP  = 480,
    parameter int V_FRONT = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] lcd_data,
    output logic [11:0] lcd_xpos,
    output logic [11:0] lcd_ypos,
    output logic        lcd_request,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output logic [23:0] lcd_rgb,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam logic [11:0] H_TOTAL = 12'(H_SYNC + H_BACK + H_DISP + H_FRONT);
    localparam logic [11:0] V_TOTAL = 12'(V_SYNC + V_BACK + V_DISP + V_FRONT);
    localparam logic [11:0] HS_END  = 12'(H_SYNC);
    localparam logic [11:0] VS_END  = 12'(V_SYNC);
    localparam logic [11:0] HA      = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] HE      = 12'(H_SYNC + H_BACK + H_DISP);
    localparam logic [11:0] VA      = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] VE      = 12'(V_SYNC + V_BACK + V_DISP);

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic        h_wrap;
    logic        v_wrap;
    logic        h_act;
    logic        h_req;
    logic        v_act;

    assign h_wrap = (h_cnt == H_TOTAL - 12'd1);
    assign v_wrap = h_wrap && (v_cnt == V_TOTAL - 12'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            h_cnt <= h_wrap ? 12'd0 : h_cnt + 12'd1;
            if (h_wrap)
                v_cnt <= v_wrap ? 12'd0 : v_cnt + 12'd1;
            // Registered so the pulse lands exactly on the cycle the counters read 0/0.
            frame_start <= v_wrap;
            if (v_wrap)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

    always_comb begin
        lcd_hs      = (h_cnt >= HS_END);
        lcd_vs      = (v_cnt >= VS_END);
        h_act       = (h_cnt >= HA) && (h_cnt < HE);
        h_req       = (h_cnt >= HA - 12'd1) && (h_cnt < HE - 12'd1);
        v_act       = (v_cnt >= VA) && (v_cnt < VE);
        lcd_de      = h_act && v_act;
        // Request runs one clock ahead to absorb the pattern stage's register.
        lcd_request = h_req && v_act;
        lcd_xpos    = lcd_request ? h_cnt - (HA - 12'd1) : 12'd0;
        lcd_ypos    = lcd_request ? v_cnt - VA : 12'd0;
        lcd_rgb     = lcd_de ? lcd_data : 24'h000000;
    end

endmodule

// File: tb/tb_lcd_timing_driver.sv
// Self-checking bench for lcd_timing_driver on a small raster (H_TOTAL 15, V_TOTAL 8),
// comparing every cycle against a model derived from elapsed cycles since reset release.
module tb_lcd_timing_driver;

    localparam int HT = 15;
    localparam int VT = 8;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] lcd_data = '0;
    logic [11:0] lcd_xpos, lcd_ypos;
    logic        lcd_request, lcd_hs, lcd_vs, lcd_de, frame_start;
    logic [23:0] lcd_rgb;
    logic [15:0] frame_cnt;

    int          n_assert = 0;
    int          n_fail = 0;
    int          t = 0;
    logic [15:0] fc_base = '0;
    bit          seen [8][4];
    int          pix_cnt = 0;
    bit          dup = 0;

    always #5 clk = ~clk;

    lcd_timing_driver #(
        .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(2), .V_DISP(4), .V_FRONT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .lcd_data(lcd_data),
        .lcd_xpos(lcd_xpos), .lcd_ypos(lcd_ypos), .lcd_request(lcd_request),
        .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de), .lcd_rgb(lcd_rgb),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    // Pattern stage: registers the requested coordinates as the pixel value.
    always @(posedge clk) lcd_data <= {lcd_xpos, lcd_ypos};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic clear_capture();
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 4; y++) seen[x][y] = 0;
        pix_cnt = 0;
        dup = 0;
    endtask

    task automatic check();
        int h, v;
        bit de, req;
        logic [15:0] efc;
        h   = t % HT;
        v   = (t / HT) % VT;
        de  = (h >= 5 && h < 13) && (v >= 3 && v < 7);
        req = (h >= 4 && h < 12) && (v >= 3 && v < 7);
        efc = fc_base + 16'(t / FT);
        chk("hs", 32'(lcd_hs), 32'(h >= 2));
        chk("vs", 32'(lcd_vs), 32'(v >= 1));
        chk("de", 32'(lcd_de), 32'(de));
        chk("request", 32'(lcd_request), 32'(req));
        chk("xpos", 32'(lcd_xpos), req ? 32'(h - 4) : 32'd0);
        chk("ypos", 32'(lcd_ypos), req ? 32'(v - 3) : 32'd0);
        chk("rgb", 32'(lcd_rgb), de ? {8'd0, 12'(h - 5), 12'(v - 3)} : 32'd0);
        chk("frame_start", 32'(frame_start), 32'(h == 0 && v == 0 && t > 0));
        chk("frame_cnt", 32'(frame_cnt), 32'(efc));
        if (h == 0 && v == 0 && t > 0) begin
            chk("pix_count", 32'(pix_cnt), 32'd32);
            chk("pix_dup", 32'(dup), 32'd0);
            clear_capture();
        end
        if (lcd_de === 1'b1) begin
            if (lcd_rgb[23:12] < 12'd8 && lcd_rgb[11:0] < 12'd4) begin
                if (seen[lcd_rgb[14:12]][lcd_rgb[1:0]]) dup = 1;
                else begin
                    seen[lcd_rgb[14:12]][lcd_rgb[1:0]] = 1;
                    pix_cnt++;
                end
            end else dup = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) t++;
        #1;
        check();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        t = 0;
        fc_base = '0;
        clear_capture();
        check();
        run(n);
        rst_n = 1'b1;
    endtask

    initial begin
        clear_capture();
        #2;
        check();
        run(3);
        rst_n = 1'b1;

        // Three frames: sync rows, active window, frame pulses at 120/240, counts 1..3.
        run(3 * FT);
        chk("frame_cnt_3", 32'(frame_cnt), 32'd3);

        // Mid-frame reset at h=7, v=4 takes effect without a clock edge.
        while ((t % FT) != 4 * HT + 7) tick();
        rst_n = 1'b0;
        #1;
        chk("async_hs", 32'(lcd_hs), 32'd0);
        chk("async_de", 32'(lcd_de), 32'd0);
        chk("async_cnt", 32'(frame_cnt), 32'd0);
        do_reset(2);
        run(2 * FT);

        // Random run lengths and random reset durations/offsets.
        for (int k = 0; k < 5; k++) begin
            run($urandom_range(1, 300));
            #($urandom_range(0, 3));
            do_reset($urandom_range(1, 3));
            run(FT + $urandom_range(0, 20));
        end

        // Preload frame_cnt to FFFF mid-frame and let one frame complete.
        run(30);
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        fc_base = 16'hFFFF - 16'(t / FT);
        check();
        while ((t % FT) != 0) tick();
        chk("frame_cnt_wrap", 32'(frame_cnt), 32'd0);
        run(FT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
